// File: rtl/cdce62002_spi_config.sv
// SPI master that writes the two CDCE62002 configuration registers, reads both back
// and reports whether the readout (address nibble excluded) matches what was written.
module cdce62002_spi_config #(
    parameter logic [31:0] REG0_VALUE = 32'h0000_0000,
    parameter logic [31:0] REG1_VALUE = 32'h0000_0001,
    parameter int unsigned CLK_DIV    = 2,
    parameter int unsigned CS_GAP     = 2
) (
    input  logic sysclk,
    input  logic reset_INV,
    input  logic start,
    input  logic abort,
    output logic spi_clk,
    output logic spi_mosi,
    input  logic spi_miso,
    output logic spi_cs_INV,
    output logic busy,
    output logic done,
    output logic verify_ok,
    output logic fail_reg
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_GAP,
        S_SHIFT_LO,
        S_SHIFT_HI,
        S_END,
        S_CHECK,
        S_DONE
    } state_t;

    localparam logic [7:0] DIV_LAST = 8'(CLK_DIV - 1);
    localparam logic [3:0] GAP_LAST = 4'(CS_GAP - 1);

    state_t      state, state_next;
    logic [7:0]  div_cnt, div_next;
    logic [4:0]  bit_cnt, bit_next;
    logic [2:0]  frame, frame_next;
    logic [3:0]  gap_cnt, gap_next;
    logic [27:0] shreg, shreg_next;
    logic [27:0] rd0, rd0_next;
    logic [1:0]  miso_sync;
    logic        clk_next, mosi_next, cs_next, busy_next, done_next, ok_next, fail_next;
    logic        tick, ok0, ok1;
    logic [4:0]  bit_inc;
    logic [31:0] tx_word;

    assign tick    = busy && (div_cnt == DIV_LAST);
    assign bit_inc = bit_cnt + 5'd1;
    // Only readout bits [31:4] are kept, so shreg ends up holding exactly the compared field
    assign ok0     = (rd0 == REG0_VALUE[31:4]);
    assign ok1     = (shreg == REG1_VALUE[31:4]);

    always_comb begin
        case (frame)
            3'd0:    tx_word = REG0_VALUE;
            3'd1:    tx_word = REG1_VALUE;
            3'd2:    tx_word = 32'h0000_000E;
            3'd4:    tx_word = 32'h0000_001E;
            default: tx_word = 32'h0000_0000;
        endcase
    end

    always_comb begin
        state_next = state;
        div_next   = (busy && !tick) ? div_cnt + 8'd1 : 8'd0;
        bit_next   = bit_cnt;
        frame_next = frame;
        gap_next   = gap_cnt;
        shreg_next = shreg;
        rd0_next   = rd0;
        clk_next   = spi_clk;
        mosi_next  = spi_mosi;
        cs_next    = spi_cs_INV;
        busy_next  = busy;
        done_next  = done;
        ok_next    = verify_ok;
        fail_next  = fail_reg;

        if (state == S_IDLE || state == S_DONE) begin
            if (start && !abort) begin
                state_next = S_GAP;
                busy_next  = 1'b1;
                done_next  = 1'b0;
                ok_next    = 1'b0;
                fail_next  = 1'b0;
                frame_next = 3'd0;
                gap_next   = 4'd0;
                bit_next   = 5'd0;
            end
        end else if (tick && abort) begin
            state_next = S_DONE;
            clk_next   = 1'b0;
            mosi_next  = 1'b0;
            cs_next    = 1'b1;
            busy_next  = 1'b0;
            done_next  = 1'b1;
            ok_next    = 1'b0;
            fail_next  = 1'b0;
        end else begin
            case (state)
                S_GAP: begin
                    if (tick) begin
                        if (gap_cnt == GAP_LAST) begin
                            gap_next   = 4'd0;
                            cs_next    = 1'b0;
                            bit_next   = 5'd0;
                            mosi_next  = tx_word[0];
                            state_next = S_SHIFT_LO;
                        end else begin
                            gap_next = gap_cnt + 4'd1;
                        end
                    end
                end
                S_SHIFT_LO: begin
                    if (tick) begin
                        clk_next   = 1'b1;
                        state_next = S_SHIFT_HI;
                        if (bit_cnt >= 5'd4) shreg_next = {miso_sync[1], shreg[27:1]};
                    end
                end
                S_SHIFT_HI: begin
                    if (tick) begin
                        clk_next = 1'b0;
                        if (bit_cnt == 5'd31) begin
                            cs_next    = 1'b1;
                            mosi_next  = 1'b0;
                            state_next = S_END;
                        end else begin
                            bit_next   = bit_inc;
                            mosi_next  = tx_word[bit_inc];
                            state_next = S_SHIFT_LO;
                        end
                    end
                end
                S_END: begin
                    if (tick) begin
                        if (frame == 3'd3) rd0_next = shreg;
                        if (frame == 3'd5) begin
                            state_next = S_CHECK;
                        end else begin
                            frame_next = frame + 3'd1;
                            state_next = S_GAP;
                        end
                    end
                end
                S_CHECK: begin
                    // shreg still holds the reg1 readout captured in the final frame
                    ok_next    = ok0 && ok1;
                    fail_next  = ok0 && !ok1;
                    busy_next  = 1'b0;
                    done_next  = 1'b1;
                    state_next = S_DONE;
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge sysclk or negedge reset_INV) begin
        if (!reset_INV) begin
            state      <= S_IDLE;
            div_cnt    <= 8'd0;
            bit_cnt    <= 5'd0;
            frame      <= 3'd0;
            gap_cnt    <= 4'd0;
            shreg      <= 28'd0;
            rd0        <= 28'd0;
            miso_sync  <= 2'b00;
            spi_clk    <= 1'b0;
            spi_mosi   <= 1'b0;
            spi_cs_INV <= 1'b1;
            busy       <= 1'b0;
            done       <= 1'b0;
            verify_ok  <= 1'b0;
            fail_reg   <= 1'b0;
        end else begin
            state      <= state_next;
            div_cnt    <= div_next;
            bit_cnt    <= bit_next;
            frame      <= frame_next;
            gap_cnt    <= gap_next;
            shreg      <= shreg_next;
            rd0        <= rd0_next;
            miso_sync  <= {miso_sync[0], spi_miso};
            spi_clk    <= clk_next;
            spi_mosi   <= mosi_next;
            spi_cs_INV <= cs_next;
            busy       <= busy_next;
            done       <= done_next;
            verify_ok  <= ok_next;
            fail_reg   <= fail_next;
        end
    end

endmodule

// File: tb/tb_cdce62002_spi_config.sv
// Directed bench for cdce62002_spi_config with a behavioural CDCE62002 that captures
// written frames and echoes configurable register contents after a read command.
module tb_cdce62002_spi_config;

    localparam logic [31:0] REG0       = 32'h8184_0320;
    localparam logic [31:0] REG1       = 32'h0000_0001;
    localparam int          CLK_DIV    = 3;
    localparam int          CS_GAP     = 2;
    localparam int          SEQ_CYCLES = 6 * CLK_DIV * (64 + CS_GAP + 1) + 1;
    localparam int          BUDGET     = SEQ_CYCLES + 200;

    logic sysclk    = 1'b0;
    logic reset_INV = 1'b0;
    logic start     = 1'b0;
    logic abort     = 1'b0;
    logic spi_miso  = 1'b0;
    logic spi_clk, spi_mosi, spi_cs_INV, busy, done, verify_ok, fail_reg;

    int checks = 0;
    int passes = 0;

    logic [31:0] echo0 = REG0;
    logic [31:0] echo1 = REG1;
    logic [31:0] out_word = '0;
    logic [31:0] cap_word = '0;
    logic        prev_cs  = 1'b1;
    logic        prev_clk = 1'b0;
    int          rise_cnt  = 0;
    int          frame_cnt = 0;
    logic [31:0] frame_words[$];
    int          frame_edges[$];

    cdce62002_spi_config #(
        .REG0_VALUE(REG0),
        .REG1_VALUE(REG1),
        .CLK_DIV   (CLK_DIV),
        .CS_GAP    (CS_GAP)
    ) dut (
        .sysclk    (sysclk),
        .reset_INV (reset_INV),
        .start     (start),
        .abort     (abort),
        .spi_clk   (spi_clk),
        .spi_mosi  (spi_mosi),
        .spi_miso  (spi_miso),
        .spi_cs_INV(spi_cs_INV),
        .busy      (busy),
        .done      (done),
        .verify_ok (verify_ok),
        .fail_reg  (fail_reg)
    );

    always #5 sysclk = ~sysclk;

    // PLL model: samples mosi on rising spi_clk, shifts miso out LSB first on falling spi_clk
    always @(spi_cs_INV or spi_clk) begin
        if (spi_cs_INV !== prev_cs) begin
            if (spi_cs_INV === 1'b0) begin
                frame_cnt++;
                rise_cnt = 0;
                cap_word = '0;
                spi_miso = out_word[0];
            end else if (spi_cs_INV === 1'b1) begin
                frame_words.push_back(cap_word);
                frame_edges.push_back(rise_cnt);
                if (rise_cnt == 32 && cap_word[31:5] == 27'd0 && cap_word[3:0] == 4'hE)
                    out_word = cap_word[4] ? echo1 : echo0;
                else
                    out_word = '0;
                spi_miso = 1'b0;
            end
            prev_cs = spi_cs_INV;
        end
        if (spi_clk !== prev_clk) begin
            if (spi_clk === 1'b1 && spi_cs_INV === 1'b0) begin
                if (rise_cnt < 32) cap_word[rise_cnt] = spi_mosi;
                rise_cnt++;
            end else if (spi_clk === 1'b0 && spi_cs_INV === 1'b0 && rise_cnt < 32) begin
                spi_miso = out_word[rise_cnt];
            end
            prev_clk = spi_clk;
        end
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checks++;
        if (observed === expected) passes++;
        else $display("[TB] FAIL %s: observed 0x%08h, expected 0x%08h", tag, observed, expected);
    endtask

    task automatic applyStimulus(input logic start_v, input logic abort_v);
        @(negedge sysclk);
        start = start_v;
        abort = abort_v;
        @(posedge sysclk);
        #1;
        start = 1'b0;
        abort = 1'b0;
    endtask

    task automatic wait_done(output int cycles);
        cycles = 0;
        while (done !== 1'b1 && cycles < BUDGET) begin
            @(posedge sysclk);
            #1;
            cycles++;
        end
    endtask

    // Returns 1 once the model is inside frame number 'frame_no' past 'rises' rising edges
    task automatic wait_frame_pos(input int base, input int frame_no, input int rises,
                                  output logic reached);
        int n;
        n = 0;
        reached = 1'b0;
        while (!reached && n < BUDGET) begin
            @(negedge sysclk);
            n++;
            if (frame_cnt - base == frame_no && rise_cnt == rises) reached = 1'b1;
        end
    endtask

    task automatic run_and_check(input string tag, input logic [2:0] exp_flags);
        int cycles;
        applyStimulus(1'b1, 1'b0);
        wait_done(cycles);
        checkOutput({tag, "_len"}, cycles, SEQ_CYCLES);
        checkOutput({tag, "_flags"}, {busy, done, verify_ok, fail_reg}, {1'b0, exp_flags});
    endtask

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        logic [31:0] exp_words[6];
        logic        idle_bad;
        logic        reached;
        int          base;
        int          fbase;
        int          cycles;

        exp_words = '{REG0, REG1, 32'h0000_000E, 32'h0, 32'h0000_001E, 32'h0};

        // Reset state and 1000 quiet cycles
        repeat (3) @(posedge sysclk);
        #1;
        checkOutput("reset_outputs", {spi_clk, spi_mosi, spi_cs_INV, busy, done, verify_ok, fail_reg},
                    7'b0010000);
        @(negedge sysclk);
        reset_INV = 1'b1;
        idle_bad = 1'b0;
        for (int i = 0; i < 1000; i++) begin
            @(negedge sysclk);
            if ({spi_clk, spi_mosi, spi_cs_INV, busy, done, verify_ok, fail_reg} !== 7'b0010000)
                idle_bad = 1'b1;
        end
        checkOutput("idle_1000_cycles", idle_bad, 1'b0);

        // start and abort together in IDLE: nothing happens
        base = frame_words.size();
        applyStimulus(1'b1, 1'b1);
        repeat (30) @(posedge sysclk);
        #1;
        checkOutput("start_abort_idle", {busy, done, spi_cs_INV}, 3'b001);
        checkOutput("start_abort_frames", frame_words.size() - base, 0);

        // Clean configure + verify
        base = frame_words.size();
        applyStimulus(1'b1, 1'b0);
        checkOutput("busy_after_start", {busy, done}, 2'b10);
        wait_done(cycles);
        checkOutput("clean_len", cycles, SEQ_CYCLES);
        checkOutput("clean_flags", {busy, done, verify_ok, fail_reg}, 4'b0110);
        checkOutput("clean_frame_count", frame_words.size() - base, 6);
        for (int i = 0; i < 6; i++) begin
            if (base + i < frame_words.size()) begin
                checkOutput($sformatf("clean_f%0d_word", i), frame_words[base + i], exp_words[i]);
                checkOutput($sformatf("clean_f%0d_edges", i), frame_edges[base + i], 32);
            end
        end

        // Readout bit 12 of reg1 flipped
        echo1 = REG1 ^ 32'h0000_1000;
        run_and_check("reg1_bad", 3'b101);

        // Both readouts bad: first failing register is reg0
        echo0 = REG0 ^ 32'h8000_0000;
        run_and_check("both_bad", 3'b100);

        // Only reg0 bad
        echo1 = REG1;
        run_and_check("reg0_bad", 3'b100);

        // Address nibble differences are ignored
        echo0 = REG0 | 32'h0000_000F;
        echo1 = 32'h0000_000E;
        run_and_check("nibble_only", 3'b110);
        echo0 = REG0;
        echo1 = REG1;

        // Abort during frame 1, bit 10
        fbase = frame_cnt;
        applyStimulus(1'b1, 1'b0);
        wait_frame_pos(fbase, 2, 10, reached);
        checkOutput("abort_reached_f1b10", reached, 1'b1);
        abort = 1'b1;
        cycles = 0;
        while (spi_cs_INV !== 1'b1 && cycles < 20) begin
            @(posedge sysclk);
            #1;
            cycles++;
        end
        checkOutput("abort_latency_ok", (cycles <= CLK_DIV + 1), 1'b1);
        checkOutput("abort_flags", {spi_cs_INV, spi_clk, spi_mosi, busy, done, verify_ok, fail_reg},
                    7'b1000100);
        @(negedge sysclk);
        abort = 1'b0;
        run_and_check("after_abort", 3'b110);

        // Async reset in frame 3, then restart with an ignored second start
        fbase = frame_cnt;
        applyStimulus(1'b1, 1'b0);
        wait_frame_pos(fbase, 4, 5, reached);
        checkOutput("reset_reached_f3", reached, 1'b1);
        #2;
        reset_INV = 1'b0;
        #1;
        checkOutput("async_reset_cs_busy", {spi_cs_INV, busy}, 2'b10);
        repeat (2) @(posedge sysclk);
        @(negedge sysclk);
        reset_INV = 1'b1;
        repeat (3) @(posedge sysclk);
        base = frame_words.size();
        applyStimulus(1'b1, 1'b0);
        repeat (20) @(posedge sysclk);
        applyStimulus(1'b1, 1'b0);
        wait_done(cycles);
        checkOutput("restart_done", cycles < BUDGET, 1'b1);
        checkOutput("restart_flags", {busy, done, verify_ok, fail_reg}, 4'b0110);
        checkOutput("restart_frame_count", frame_words.size() - base, 6);
        if (frame_words.size() > base)
            checkOutput("restart_first_word", frame_words[base], REG0);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
